// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-supply side of the R-type datapath:
// FSM state encodings, halt encoding and instruction field positions.
package instr_fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef logic [1:0] fetchState_t;
  localparam fetchState_t IDLE    = 2'd0;
  localparam fetchState_t FETCH   = 2'd1;
  localparam fetchState_t PRESENT = 2'd2;
  localparam fetchState_t DONE    = 2'd3;

  // Field positions shared with the datapath decoder.
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  // Assemble an R-type word; shamt is left zero.
  function automatic logic [INSTR_W-1:0] rType(input logic [5:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [5:0] funct);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_MSB:OP_LSB]       = op;
    w[RS_MSB:RS_LSB]       = rs;
    w[RT_MSB:RT_LSB]       = rt;
    w[RD_MSB:RD_LSB]       = rd;
    w[FUNCT_MSB:FUNCT_LSB] = funct;
    return w;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// DEPTH x 32 instruction RAM: synchronous write, registered read.
// A read that coincides with a write to the same word returns the new data.
module instr_mem
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic               clk,
  input  logic               wrEn,
  input  logic [AW-1:0]      wrAddr,
  input  logic [INSTR_W-1:0] wrData,
  input  logic               rdEn,
  input  logic [AW-1:0]      rdAddr,
  output logic [INSTR_W-1:0] rdData
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= (wrEn && (wrAddr == rdAddr)) ? wrData : mem[rdAddr];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction supplier: walks instruction memory from PC 0, presents each word
// with valid/ready, counts zero-flag results and stops on HALT or end of memory.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned        DEPTH     = 64,
  parameter int unsigned        AW        = 6,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               zf_in,
  output logic [31:0]        pc,
  output logic [15:0]        zf_count,
  output logic               busy,
  output logic               done
);

  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  fetchState_t        state, stateNext;
  logic [AW-1:0]      pcWord, pcWordNext;
  logic [INSTR_W-1:0] instrNext;
  logic               validNext;
  logic [15:0]        zfNext;
  logic               memWrEn, memRdEn;
  logic [AW-1:0]      memRdAddr;
  logic [INSTR_W-1:0] memRdData;

  instr_mem #(.DEPTH(DEPTH), .AW(AW)) uMem (
    .clk    (clk),
    .wrEn   (memWrEn),
    .wrAddr (load_addr),
    .wrData (load_data),
    .rdEn   (memRdEn),
    .rdAddr (memRdAddr),
    .rdData (memRdData)
  );

  // The word is read on the edge entering FETCH, so it is available for the
  // HALT decision during FETCH and lands in instr at the end of it.
  always_comb begin
    stateNext  = state;
    pcWordNext = pcWord;
    instrNext  = instr;
    validNext  = instr_valid;
    zfNext     = zf_count;
    memWrEn    = 1'b0;
    memRdEn    = 1'b0;
    memRdAddr  = pcWord;
    case (state)
      IDLE, DONE: begin
        validNext = 1'b0;
        memWrEn   = load_en;
        if (start) begin
          stateNext  = FETCH;
          pcWordNext = '0;
          zfNext     = '0;
          memRdEn    = 1'b1;
          memRdAddr  = '0;
        end
      end
      FETCH: begin
        if (memRdData == HALT_WORD) begin
          stateNext = DONE;
          validNext = 1'b0;
        end else begin
          instrNext = memRdData;
          validNext = 1'b1;
          stateNext = PRESENT;
        end
      end
      PRESENT: begin
        if (instr_valid && instr_ready) begin
          validNext = 1'b0;
          if (zf_in && (zf_count != 16'hFFFF)) zfNext = zf_count + 16'd1;
          if (pcWord == LAST_WORD) begin
            stateNext = DONE;
          end else begin
            pcWordNext = pcWord + AW'(1);
            stateNext  = FETCH;
            memRdEn    = 1'b1;
            memRdAddr  = pcWord + AW'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // busy/done are registered from the next state so they track state exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcWord      <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      zf_count    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      pcWord      <= pcWordNext;
      instr       <= instrNext;
      instr_valid <= validNext;
      zf_count    <= zfNext;
      busy        <= (stateNext == FETCH) || (stateNext == PRESENT);
      done        <= (stateNext == DONE);
    end
  end

  assign pc = 32'(pcWord) << 2;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: normal run, stall, zero-flag count, loads,
// reset mid-run and a full-memory walk.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic          start = 1'b0;
  logic          instr_ready = 1'b0;
  logic          zf_in = 1'b0;
  logic [31:0]   instr, pc;
  logic          instr_valid, busy, done;
  logic [15:0]   zf_count;

  int checks = 0;
  int failures = 0;
  logic [31:0] prog [4];

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(DEPTH), .AW(AW), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .zf_in       (zf_in),
    .pc          (pc),
    .zf_count    (zf_count),
    .busy        (busy),
    .done        (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic loadWord(input logic [AW-1:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic startRun();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered with the DUT in FETCH; leaves it just after the handshake edge.
  task automatic stepWord(input string tag, input logic [31:0] w, input logic [31:0] p,
                          input logic z);
    instr_ready = 1'b0;
    tick();
    checkVal({tag, "_valid"}, 32'(instr_valid), 32'd1);
    checkVal({tag, "_instr"}, instr, w);
    checkVal({tag, "_pc"}, pc, p);
    instr_ready = 1'b1; zf_in = z;
    tick();
    instr_ready = 1'b0; zf_in = 1'b0;
    checkVal({tag, "_ack"}, 32'(instr_valid), 32'd0);
  endtask

  // Three program words then the HALT fetch; ends in DONE.
  task automatic runProg(input string tag, input logic z0, input logic z1, input logic z2,
                         input logic [15:0] expZf);
    stepWord({tag, "_w0"}, prog[0], 32'd0, z0);
    stepWord({tag, "_w1"}, prog[1], 32'd4, z1);
    stepWord({tag, "_w2"}, prog[2], 32'd8, z2);
    tick();
    checkVal({tag, "_done"}, 32'(done), 32'd1);
    checkVal({tag, "_busy"}, 32'(busy), 32'd0);
    checkVal({tag, "_pc_end"}, pc, 32'd12);
    checkVal({tag, "_zf"}, 32'(zf_count), 32'(expZf));
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    checkVal("rst_pc", pc, 32'd0);
    checkVal("rst_instr", instr, 32'd0);
    checkVal("rst_valid", 32'(instr_valid), 32'd0);
    checkVal("rst_zf", 32'(zf_count), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_done", 32'(done), 32'd0);

    prog[0] = rType(6'd0, 5'd1, 5'd2, 5'd3, 6'd32);
    prog[1] = rType(6'd0, 5'd4, 5'd5, 5'd6, 6'd34);
    prog[2] = rType(6'd0, 5'd7, 5'd8, 5'd9, 6'd36);
    prog[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) loadWord(AW'(i), prog[i]);

    // Normal run with zero flags 1,0,1.
    startRun();
    checkVal("t1_busy", 32'(busy), 32'd1);
    checkVal("t1_lat_valid", 32'(instr_valid), 32'd0);
    runProg("t1", 1'b1, 1'b0, 1'b1, 16'd2);

    // Restart clears the counter; stall word 1 for five cycles.
    startRun();
    checkVal("t2_zf_clr", 32'(zf_count), 32'd0);
    checkVal("t2_done_clr", 32'(done), 32'd0);
    stepWord("t2_w0", prog[0], 32'd0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkVal("t2_stall_valid", 32'(instr_valid), 32'd1);
      checkVal("t2_stall_instr", instr, prog[1]);
      checkVal("t2_stall_pc", pc, 32'd4);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checkVal("t2_pc_adv", pc, 32'd8);
    checkVal("t2_ack", 32'(instr_valid), 32'd0);
    stepWord("t2_w2", prog[2], 32'd8, 1'b0);
    tick();
    checkVal("t2_done", 32'(done), 32'd1);
    checkVal("t2_pc_end", pc, 32'd12);

    // Load during PRESENT is ignored.
    startRun();
    tick();
    load_en = 1'b1; load_addr = AW'(1); load_data = 32'h1234_5678;
    tick();
    load_en = 1'b0;
    checkVal("t3_present_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    stepWord("t3_w1_old", prog[1], 32'd4, 1'b0);
    stepWord("t3_w2", prog[2], 32'd8, 1'b0);
    tick();
    checkVal("t3_done", 32'(done), 32'd1);
    loadWord(AW'(1), 32'h1234_5678);
    prog[1] = 32'h1234_5678;
    startRun();
    runProg("t3b", 1'b0, 1'b1, 1'b0, 16'd1);

    // Load to address 0 together with start is seen by the first fetch.
    prog[0] = rType(6'd0, 5'd10, 5'd11, 5'd12, 6'd37);
    load_en = 1'b1; load_addr = '0; load_data = prog[0]; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    runProg("t4", 1'b1, 1'b1, 1'b1, 16'd3);

    // Reset while presenting word 1, with ready high in the reset cycle.
    startRun();
    stepWord("t5_w0", prog[0], 32'd0, 1'b1);
    tick();
    checkVal("t5_pre_zf", 32'(zf_count), 32'd1);
    rst_n = 1'b0; instr_ready = 1'b1; zf_in = 1'b1;
    tick();
    rst_n = 1'b1; instr_ready = 1'b0; zf_in = 1'b0;
    checkVal("t5_valid", 32'(instr_valid), 32'd0);
    checkVal("t5_pc", pc, 32'd0);
    checkVal("t5_zf", 32'(zf_count), 32'd0);
    checkVal("t5_busy", 32'(busy), 32'd0);
    checkVal("t5_done", 32'(done), 32'd0);
    startRun();
    runProg("t5r", 1'b0, 1'b0, 1'b0, 16'd0);

    // Full memory without HALT: DEPTH handshakes, stop at the last word.
    for (int i = 0; i < DEPTH; i++) loadWord(AW'(i), 32'hA000_0000 | 32'(i));
    startRun();
    for (int i = 0; i < DEPTH; i++)
      stepWord("t6", 32'hA000_0000 | 32'(i), 32'(4 * i), 1'(i & 1));
    checkVal("t6_done", 32'(done), 32'd1);
    checkVal("t6_pc", pc, 32'(4 * (DEPTH - 1)));
    checkVal("t6_zf", 32'(zf_count), 32'(DEPTH / 2));
    tick();
    checkVal("t6_pc_hold", pc, 32'(4 * (DEPTH - 1)));
    checkVal("t6_done_hold", 32'(done), 32'd1);
    checkVal("t6_valid_hold", 32'(instr_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
